// File: rtl/axis_pkt_arbiter.sv
// Packet-aware round-robin arbiter: N_SRC AXI-Stream sources share one output,
// with the grant held for a whole packet and a beat limit that force-terminates runaway packets.
module axis_pkt_arbiter #(
   parameter int N_SRC     = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_SRC*DATA_W-1:0]       s_data,
   input  logic [N_SRC-1:0]              s_valid,
   output logic [N_SRC-1:0]              s_ready,
   input  logic [N_SRC-1:0]              s_last,
   output logic [DATA_W-1:0]             m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          m_last,
   output logic [N_SRC-1:0]              grant,
   output logic                          busy,
   output logic [$clog2(MAX_BEATS+1)-1:0] beat_cnt,
   output logic                          err_trunc
);

   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   // Handshake: a beat moves on a rising edge where m_valid && m_ready; the
   // granted source sees s_ready = m_ready, every other source sees 0.
   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [N_SRC-1:0]   grant_q, grant_d;
   logic [CNT_W-1:0]   beat_q, beat_d;
   logic               err_q, err_d;

   logic [DATA_W-1:0]  g_data;
   logic               g_valid;
   logic               g_last;
   logic [PTR_W-1:0]   g_idx;
   logic               at_limit;
   logic               xfer;

   logic               found;
   logic [N_SRC-1:0]   pick_oh;
   logic [PTR_W:0]     scan_sum;
   logic [PTR_W-1:0]   scan_idx;

   // Granted-source mux; grant_q is one-hot or zero, so at most one term hits.
   always_comb begin
      g_data  = '0;
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_idx   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q[i]) begin
            g_data  = s_data[i*DATA_W +: DATA_W];
            g_valid = s_valid[i];
            g_last  = s_last[i];
            g_idx   = PTR_W'(i);
         end
      end
   end

   assign busy      = (state_q == BUSY);
   assign at_limit  = (beat_q == CNT_W'(MAX_BEATS - 1));
   assign m_valid   = busy & g_valid;
   assign m_data    = busy ? g_data : '0;
   assign m_last    = busy & (g_last | at_limit);
   assign s_ready   = busy ? (grant_q & {N_SRC{m_ready}}) : '0;
   assign xfer      = m_valid & m_ready;
   assign grant     = grant_q;
   assign beat_cnt  = beat_q;
   assign err_trunc = err_q;

   // Round-robin scan starting at ptr_q; ptr_q + k stays below 2*N_SRC.
   always_comb begin
      found    = 1'b0;
      pick_oh  = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < N_SRC; k++) begin
         scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (scan_sum >= (PTR_W+1)'(N_SRC)) begin
            scan_sum = scan_sum - (PTR_W+1)'(N_SRC);
         end
         scan_idx = scan_sum[PTR_W-1:0];
         if (!found && s_valid[scan_idx]) begin
            found             = 1'b1;
            pick_oh[scan_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      beat_d  = beat_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BUSY;
               grant_d = pick_oh;
               beat_d  = '0;
            end
         end
         BUSY: begin
            if (xfer) begin
               if (m_last) begin
                  state_d = IDLE;
                  grant_d = '0;
                  beat_d  = '0;
                  ptr_d   = (int'(g_idx) == N_SRC - 1) ? '0 : g_idx + 1'b1;
                  // Last forced by the beat limit rather than by the source.
                  if (!g_last) begin
                     err_d = 1'b1;
                  end
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: per-source beat queues drive the inputs,
// a monitor collects forwarded beats, and an expected queue holds hand-computed results.
module tb_axis_pkt_arbiter;

   localparam int N_SRC     = 4;
   localparam int DATA_W    = 32;
   localparam int MAX_BEATS = 16;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);

   logic                    clk;
   logic                    reset;
   logic [N_SRC*DATA_W-1:0] s_data;
   logic [N_SRC-1:0]        s_valid;
   logic [N_SRC-1:0]        s_ready;
   logic [N_SRC-1:0]        s_last;
   logic [DATA_W-1:0]       m_data;
   logic                    m_valid;
   logic                    m_ready;
   logic                    m_last;
   logic [N_SRC-1:0]        grant;
   logic                    busy;
   logic [CNT_W-1:0]        beat_cnt;
   logic                    err_trunc;

   axis_pkt_arbiter #(.N_SRC(N_SRC), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
      .clk(clk), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .grant(grant), .busy(busy), .beat_cnt(beat_cnt), .err_trunc(err_trunc)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;

   logic [DATA_W:0]  src_q [N_SRC][$];
   logic [DATA_W:0]  exp_q[$];
   logic [DATA_W:0]  got_q[$];
   logic [N_SRC-1:0] hold;

   always @(posedge clk) begin
      if (reset && m_valid && m_ready) got_q.push_back({m_last, m_data});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver tasks
   task automatic drive();
      for (int i = 0; i < N_SRC; i++) begin
         if (src_q[i].size() != 0) begin
            s_valid[i]                 = !hold[i];
            s_data[i*DATA_W +: DATA_W] = src_q[i][0][DATA_W-1:0];
            s_last[i]                  = src_q[i][0][DATA_W];
         end else begin
            s_valid[i]                 = 1'b0;
            s_data[i*DATA_W +: DATA_W] = '0;
            s_last[i]                  = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      for (int i = 0; i < N_SRC; i++) begin
         if (s_valid[i] && s_ready[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      end
      #1;
      drive();
      #1;
   endtask

   task automatic load(input int src, input logic [DATA_W-1:0] data, input logic last);
      src_q[src].push_back({last, data});
   endtask

   task automatic expb(input logic [DATA_W-1:0] data, input logic last);
      exp_q.push_back({last, data});
   endtask

   task automatic check_got(input string tag);
      logic [DATA_W:0] e;
      logic [DATA_W:0] g;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
         chk(tag, 64'(g), 64'(e));
      end
      chk({tag, "_extra"}, 64'(got_q.size()), 64'd0);
      got_q.delete();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_grant"},  64'(grant),    64'd0);
      chk({tag, "_busy"},   64'(busy),     64'd0);
      chk({tag, "_mvalid"}, 64'(m_valid),  64'd0);
      chk({tag, "_sready"}, 64'(s_ready),  64'd0);
      chk({tag, "_beat"},   64'(beat_cnt), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk_idle("rst");
      chk("rst_mlast", 64'(m_last), 64'd0);
      chk("rst_mdata", 64'(m_data), 64'd0);
      chk("rst_err",   64'(err_trunc), 64'd0);
      for (int i = 0; i < N_SRC; i++) src_q[i].delete();
      drive();
      cyc();
      reset = 1'b1;
      got_q.delete();
   endtask

   initial begin
      int pat [7] = '{1, 0, 1, 0, 1, 0, 1};
      int b;
      reset   = 1'b0;
      m_ready = 1'b0;
      hold    = '0;
      drive();
      #3;
      do_reset();

      // Single 3-beat packet from src1
      m_ready = 1'b1;
      load(1, 32'hA1, 0); load(1, 32'hA2, 0); load(1, 32'hA3, 1);
      drive();
      #1;
      chk("t1_pre_grant", 64'(grant), 64'd0);
      cyc();
      chk("t1_grant",  64'(grant),   64'b0010);
      chk("t1_busy",   64'(busy),    64'd1);
      chk("t1_sready", 64'(s_ready), 64'b0010);
      chk("t1_d0",     64'(m_data),  64'hA1);
      cyc();
      chk("t1_d1",     64'(m_data),  64'hA2);
      chk("t1_beat1",  64'(beat_cnt), 64'd1);
      cyc();
      chk("t1_d2",     64'(m_data),  64'hA3);
      chk("t1_last2",  64'(m_last),  64'd1);
      cyc();
      chk_idle("t1_end");
      expb(32'hA1, 0); expb(32'hA2, 0); expb(32'hA3, 1);
      check_got("t1_beats");

      // ptr now 2: three 1-beat requesters are served 2, 0, 1
      load(0, 32'hB0, 1); load(1, 32'hB1, 1); load(2, 32'hB2, 1);
      drive();
      cyc(); chk("t1b_g0", 64'(grant), 64'b0100);
      cyc(); chk("t1b_i0", 64'(grant), 64'd0);
      cyc(); chk("t1b_g1", 64'(grant), 64'b0001);
      cyc(); chk("t1b_i1", 64'(grant), 64'd0);
      cyc(); chk("t1b_g2", 64'(grant), 64'b0010);
      cyc(); chk("t1b_i2", 64'(grant), 64'd0);
      expb(32'hB2, 1); expb(32'hB0, 1); expb(32'hB1, 1);
      check_got("t1b_beats");

      // Round-robin src0 / src2 after reset
      do_reset();
      load(0, 32'h10, 0); load(0, 32'h11, 1); load(0, 32'h12, 0); load(0, 32'h13, 1);
      load(2, 32'h20, 0); load(2, 32'h21, 1); load(2, 32'h22, 0); load(2, 32'h23, 1);
      drive();
      for (int r = 0; r < 4; r++) begin
         logic [N_SRC-1:0] eg;
         eg = (r % 2 == 0) ? 4'b0001 : 4'b0100;
         cyc(); chk("t2_grant_a", 64'(grant), 64'(eg));
         cyc(); chk("t2_grant_b", 64'(grant), 64'(eg));
         cyc(); chk("t2_gap",     64'(grant), 64'd0);
      end
      expb(32'h10, 0); expb(32'h11, 1); expb(32'h20, 0); expb(32'h21, 1);
      expb(32'h12, 0); expb(32'h13, 1); expb(32'h22, 0); expb(32'h23, 1);
      check_got("t2_beats");

      // Backpressure on a 4-beat src3 packet
      for (int k = 0; k < 4; k++) load(3, 32'h30 + k, (k == 3));
      drive();
      cyc();
      chk("t3_grant", 64'(grant), 64'b1000);
      b = 0;
      for (int k = 0; k < 7; k++) begin
         m_ready = pat[k][0];
         #1;
         chk("t3_sready", 64'(s_ready),  pat[k] != 0 ? 64'b1000 : 64'd0);
         chk("t3_data",   64'(m_data),   64'(32'h30 + b));
         chk("t3_beat",   64'(beat_cnt), 64'(b));
         chk("t3_last",   64'(m_last),   64'(b == 3));
         if (pat[k] != 0) b++;
         cyc();
      end
      m_ready = 1'b1;
      chk_idle("t3_end");
      for (int k = 0; k < 4; k++) expb(32'h30 + k, (k == 3));
      check_got("t3_beats");

      // Truncation: 20-beat packet with MAX_BEATS=16
      for (int k = 0; k < 20; k++) load(0, 32'h100 + k, (k == 19));
      drive();
      cyc();
      for (int k = 0; k < 16; k++) begin
         chk("t4_data", 64'(m_data),   64'(32'h100 + k));
         chk("t4_last", 64'(m_last),   64'(k == 15));
         chk("t4_beat", 64'(beat_cnt), 64'(k));
         cyc();
      end
      chk("t4_err",  64'(err_trunc), 64'd1);
      chk("t4_busy", 64'(busy),      64'd0);
      cyc();
      chk("t4_regrant", 64'(grant), 64'b0001);
      for (int k = 0; k < 4; k++) begin
         chk("t4_tail_data", 64'(m_data), 64'(32'h110 + k));
         chk("t4_tail_last", 64'(m_last), 64'(k == 3));
         cyc();
      end
      chk("t4_err_sticky", 64'(err_trunc), 64'd1);
      for (int k = 0; k < 20; k++) expb(32'h100 + k, (k == 15) || (k == 19));
      check_got("t4_beats");

      // Bubble hold: src2 stalls while src1 requests
      for (int k = 0; k < 4; k++) load(2, 32'h40 + k, (k == 3));
      drive();
      cyc();
      chk("t6_grant", 64'(grant), 64'b0100);
      cyc();
      hold[2] = 1'b1;
      load(1, 32'h50, 1);
      drive();
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("t6_hold_grant",  64'(grant),   64'b0100);
         chk("t6_hold_mvalid", 64'(m_valid), 64'd0);
         cyc();
      end
      hold[2] = 1'b0;
      drive();
      #1;
      for (int k = 1; k < 4; k++) begin
         chk("t6_data",  64'(m_data), 64'(32'h40 + k));
         chk("t6_grant2", 64'(grant), 64'b0100);
         cyc();
      end
      chk("t6_gap", 64'(grant), 64'd0);
      cyc();
      chk("t6_src1", 64'(grant), 64'b0010);
      cyc();
      for (int k = 0; k < 4; k++) expb(32'h40 + k, (k == 3));
      expb(32'h50, 1);
      check_got("t6_beats");

      // Asynchronous reset on beat 2 of a 5-beat packet
      for (int k = 0; k < 5; k++) load(1, 32'h60 + k, (k == 4));
      drive();
      cyc();
      cyc();
      chk("t5_pre_data", 64'(m_data), 64'h61);
      #2;
      reset = 1'b0;
      #1;
      chk_idle("t5_async");
      chk("t5_err_clr", 64'(err_trunc), 64'd0);
      for (int i = 0; i < N_SRC; i++) src_q[i].delete();
      drive();
      cyc();
      reset = 1'b1;
      expb(32'h60, 0);
      check_got("t5_beats");
      load(0, 32'h70, 1); load(1, 32'h71, 1); load(3, 32'h73, 1);
      drive();
      cyc(); chk("t5_g0", 64'(grant), 64'b0001);
      cyc();
      cyc(); chk("t5_g1", 64'(grant), 64'b0010);
      cyc();
      cyc(); chk("t5_g3", 64'(grant), 64'b1000);
      cyc();
      chk_idle("t5_end");
      expb(32'h70, 1); expb(32'h71, 1); expb(32'h73, 1);
      check_got("t5_after");

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
